// File: rtl/commit_trace_pkg.sv
// Shared widths, per-lane commit record and lane priority helper for the commit trace path.
package commit_trace_pkg;

   localparam int unsigned PC_W       = 40;
   localparam int unsigned INST_W     = 32;
   localparam int unsigned XLEN       = 64;
   localparam int unsigned LREG_W     = 5;
   localparam int unsigned RTYPE_W    = 3;
   localparam int unsigned LANE_IDX_W = 3;
   localparam int unsigned MAX_LANES  = 1 << LANE_IDX_W;

   typedef struct packed {
      logic [LREG_W-1:0]  ldst;
      logic [RTYPE_W-1:0] dst_rtype;
      logic [PC_W-1:0]    pc;
      logic [INST_W-1:0]  inst;
      logic [XLEN-1:0]    wdata;
   } commit_lane_t;

   function automatic logic [LANE_IDX_W-1:0] lowest_set_bit(input logic [MAX_LANES-1:0] mask);
      logic [LANE_IDX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if (mask[i]) idx = LANE_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Synchronous DEPTH-entry FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module commit_trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/commit_trace_serializer.sv
// Buffers multi-lane ROB commit bundles and replays them one retired uop per handshake,
// in lane order, tagged with a running retire sequence number.
module commit_trace_serializer
   import commit_trace_pkg::*;
#(
   parameter int unsigned RETIRE_WIDTH = 6,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [7:0]                        hartid,
   input  logic [RETIRE_WIDTH-1:0]           commit_arch_valids,
   input  logic [LREG_W*RETIRE_WIDTH-1:0]    commit_ldst,
   input  logic [RTYPE_W*RETIRE_WIDTH-1:0]   commit_dst_rtype,
   input  logic [PC_W*RETIRE_WIDTH-1:0]      commit_debug_pc,
   input  logic [INST_W*RETIRE_WIDTH-1:0]    commit_debug_inst,
   input  logic [XLEN*RETIRE_WIDTH-1:0]      commit_debug_wdata,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [7:0]                        out_hartid,
   output logic [PC_W-1:0]                   out_pc,
   output logic [INST_W-1:0]                 out_inst,
   output logic [LREG_W-1:0]                 out_ldst,
   output logic [RTYPE_W-1:0]                out_dst_rtype,
   output logic [XLEN-1:0]                   out_wdata,
   output logic [LANE_IDX_W-1:0]             out_lane,
   output logic [31:0]                       out_seq,
   output logic                              overflow,
   output logic [15:0]                       drop_count
);

   typedef struct packed {
      logic [RETIRE_WIDTH-1:0]              mask;
      commit_lane_t [RETIRE_WIDTH-1:0]      lanes;
   } bundle_t;

   localparam int unsigned BUNDLE_W = $bits(bundle_t);
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

   bundle_t                 push_bundle;
   bundle_t                 head_bundle;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CNT_W-1:0]        fifo_count;
   logic                    commit_push;
   logic                    push_accepted;
   logic                    fire;
   logic                    last_lane;
   logic                    pop;
   logic [RETIRE_WIDTH-1:0] done_q;
   logic [RETIRE_WIDTH-1:0] rem_mask;
   logic [RETIRE_WIDTH-1:0] sel_onehot;
   logic [LANE_IDX_W-1:0]   sel_lane;
   commit_lane_t            sel_data;

   always_comb begin
      push_bundle      = '0;
      push_bundle.mask = commit_arch_valids;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         push_bundle.lanes[i].ldst      = commit_ldst[LREG_W*i +: LREG_W];
         push_bundle.lanes[i].dst_rtype = commit_dst_rtype[RTYPE_W*i +: RTYPE_W];
         push_bundle.lanes[i].pc        = commit_debug_pc[PC_W*i +: PC_W];
         push_bundle.lanes[i].inst      = commit_debug_inst[INST_W*i +: INST_W];
         push_bundle.lanes[i].wdata     = commit_debug_wdata[XLEN*i +: XLEN];
      end
   end

   commit_trace_fifo #(
      .WIDTH (BUNDLE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (commit_push),
      .push_data (push_bundle),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head_data (head_bundle)
   );

   // rem_mask tracks the head bundle's unsent lanes as its stored mask minus lanes already emitted,
   // so a bundle reaching head (including a same-cycle bypass) needs no separate load.
   assign rem_mask   = head_bundle.mask & ~done_q;
   assign sel_lane   = lowest_set_bit(MAX_LANES'(rem_mask));
   assign sel_onehot = RETIRE_WIDTH'(1) << sel_lane;

   assign out_valid     = ~fifo_empty;
   assign fire          = out_valid & out_ready;
   assign last_lane     = ((rem_mask & ~sel_onehot) == '0);
   assign pop           = fire & last_lane;
   assign commit_push   = |commit_arch_valids;
   assign push_accepted = commit_push & (~fifo_full | pop);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         if (sel_lane == LANE_IDX_W'(i)) sel_data = head_bundle.lanes[i];
      end
   end

   // Data outputs read as zero whenever nothing is presented.
   assign out_pc        = out_valid ? sel_data.pc        : '0;
   assign out_inst      = out_valid ? sel_data.inst      : '0;
   assign out_ldst      = out_valid ? sel_data.ldst      : '0;
   assign out_dst_rtype = out_valid ? sel_data.dst_rtype : '0;
   assign out_wdata     = out_valid ? sel_data.wdata     : '0;
   assign out_lane      = out_valid ? sel_lane           : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         done_q     <= '0;
         out_seq    <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         out_hartid <= '0;
      end else begin
         out_hartid <= hartid;
         if (fire) begin
            out_seq <= out_seq + 32'd1;
            done_q  <= last_lane ? '0 : (done_q | sel_onehot);
         end
         if (commit_push && !push_accepted) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) assert (fifo_count <= CNT_W'(DEPTH));
   end

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed table plus randomized traffic against a queue-based model of the commit serializer.
module tb_commit_trace_serializer;

   localparam int RW    = 6;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             reset;
   logic [7:0]       hartid;
   logic [RW-1:0]    valids;
   logic             out_ready;
   logic [39:0]      lpc   [RW];
   logic [31:0]      linst [RW];
   logic [4:0]       lldst [RW];
   logic [2:0]       lrt   [RW];
   logic [63:0]      lwd   [RW];
   logic [5*RW-1:0]  ldst_bus;
   logic [3*RW-1:0]  rt_bus;
   logic [40*RW-1:0] pc_bus;
   logic [32*RW-1:0] inst_bus;
   logic [64*RW-1:0] wd_bus;

   for (genvar g = 0; g < RW; g++) begin : g_pack
      assign ldst_bus[5*g +: 5]  = lldst[g];
      assign rt_bus[3*g +: 3]    = lrt[g];
      assign pc_bus[40*g +: 40]  = lpc[g];
      assign inst_bus[32*g +: 32] = linst[g];
      assign wd_bus[64*g +: 64]  = lwd[g];
   end

   logic        out_valid;
   logic [7:0]  out_hartid;
   logic [39:0] out_pc;
   logic [31:0] out_inst;
   logic [4:0]  out_ldst;
   logic [2:0]  out_dst_rtype;
   logic [63:0] out_wdata;
   logic [2:0]  out_lane;
   logic [31:0] out_seq;
   logic        overflow;
   logic [15:0] drop_count;

   commit_trace_serializer #(
      .RETIRE_WIDTH (RW),
      .DEPTH        (DEPTH)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .hartid             (hartid),
      .commit_arch_valids (valids),
      .commit_ldst        (ldst_bus),
      .commit_dst_rtype   (rt_bus),
      .commit_debug_pc    (pc_bus),
      .commit_debug_inst  (inst_bus),
      .commit_debug_wdata (wd_bus),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_hartid         (out_hartid),
      .out_pc             (out_pc),
      .out_inst           (out_inst),
      .out_ldst           (out_ldst),
      .out_dst_rtype      (out_dst_rtype),
      .out_wdata          (out_wdata),
      .out_lane           (out_lane),
      .out_seq            (out_seq),
      .overflow           (overflow),
      .drop_count         (drop_count)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: a flat queue of pending uops in emission order, plus the uop count of each
   // buffered bundle (the number of entries is what the FIFO capacity limits).
   typedef struct {
      logic [39:0] pc;
      logic [31:0] inst;
      logic [4:0]  ldst;
      logic [2:0]  rtype;
      logic [63:0] wdata;
      logic [2:0]  lane;
   } uop_t;

   uop_t        uq[$];
   int          bsz[$];
   logic [31:0] m_seq;
   bit          m_ovf;
   int          m_drops;
   logic [7:0]  m_hart;

   task automatic model_step();
      bit fire, pop, push, acc;
      int n;
      if (reset) begin
         uq.delete();
         bsz.delete();
         m_seq   = '0;
         m_ovf   = 1'b0;
         m_drops = 0;
         m_hart  = '0;
         return;
      end
      fire = (uq.size() > 0) && out_ready;
      pop  = fire && (bsz[0] == 1);
      push = (valids != '0);
      acc  = push && ((bsz.size() < DEPTH) || pop);
      if (fire) begin
         void'(uq.pop_front());
         m_seq  = m_seq + 32'd1;
         bsz[0] = bsz[0] - 1;
         if (bsz[0] == 0) void'(bsz.pop_front());
      end
      if (acc) begin
         n = 0;
         for (int i = 0; i < RW; i++) begin
            if (valids[i]) begin
               uq.push_back('{lpc[i], linst[i], lldst[i], lrt[i], lwd[i], 3'(i)});
               n++;
            end
         end
         bsz.push_back(n);
      end else if (push) begin
         m_ovf = 1'b1;
         if (m_drops < 65535) m_drops++;
      end
      m_hart = hartid;
   endtask

   task automatic check_model();
      chk("valid", 64'(out_valid), 64'(uq.size() > 0));
      chk("seq", 64'(out_seq), 64'(m_seq));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      chk("hartid", 64'(out_hartid), 64'(m_hart));
      if (uq.size() > 0) begin
         chk("lane", 64'(out_lane), 64'(uq[0].lane));
         chk("pc", 64'(out_pc), 64'(uq[0].pc));
         chk("inst", 64'(out_inst), 64'(uq[0].inst));
         chk("ldst", 64'(out_ldst), 64'(uq[0].ldst));
         chk("rtype", 64'(out_dst_rtype), 64'(uq[0].rtype));
         chk("wdata", out_wdata, uq[0].wdata);
      end
   endtask

   // Drives one cycle's inputs (applied at the next rising edge) and advances the model.
   task automatic drive(input bit rst, input logic [5:0] mask, input logic [39:0] base,
                        input bit rdy, input bit rnd_pc);
      reset     = rst;
      valids    = mask;
      out_ready = rdy;
      hartid    = 8'($urandom);
      for (int i = 0; i < RW; i++) begin
         lpc[i]   = rnd_pc ? 40'({$urandom, $urandom}) : base + 40'(4 * i);
         linst[i] = $urandom;
         lldst[i] = 5'($urandom);
         lrt[i]   = 3'($urandom);
         lwd[i]   = {$urandom, $urandom};
      end
      model_step();
   endtask

   typedef struct {
      bit          rst;
      logic [5:0]  mask;
      logic [39:0] base;
      bit          rdy;
      bit          ev;
      logic [2:0]  elane;
      logic [39:0] epc;
      logic [31:0] eseq;
      bit          eovf;
      logic [15:0] edrop;
   } row_t;

   row_t rows[$];

   task automatic add(input bit rst, input logic [5:0] mask, input logic [39:0] base,
                      input bit rdy, input bit ev, input logic [2:0] elane,
                      input logic [39:0] epc, input logic [31:0] eseq, input bit eovf,
                      input logic [15:0] edrop);
      rows.push_back('{rst, mask, base, rdy, ev, elane, epc, eseq, eovf, edrop});
   endtask

   initial begin
      // Expected outputs in each row are sampled before that row's inputs take effect.
      add(0, 6'h01, 40'h80000000, 1, 0, 0, 0, 0, 0, 0);
      add(0, 6'h00, 0, 1, 1, 0, 40'h80000000, 0, 0, 0);
      add(1, 6'h3F, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 6'h25, 40'h100, 1, 0, 0, 0, 0, 0, 0);
      add(0, 6'h00, 0, 1, 1, 0, 40'h100, 0, 0, 0);
      add(0, 6'h00, 0, 1, 1, 2, 40'h108, 1, 0, 0);
      add(0, 6'h3F, 40'h200, 1, 1, 5, 40'h114, 2, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 6'h00, 0, 0, 1, 0, 40'h200, 3, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 6'h00, 0, 1, 1, 3'(i), 40'h200 + 40'(4 * i), 3 + i, 0, 0);
      add(0, 6'h01, 40'h300, 0, 0, 0, 0, 9, 0, 0);
      for (int i = 1; i < 5; i++) add(0, 6'h01, 40'h300 + 40'(16 * i), 0, 1, 0, 40'h300, 9, 0, 0);
      add(0, 6'h00, 0, 0, 1, 0, 40'h300, 9, 1, 1);
      for (int i = 0; i < 4; i++) add(0, 6'h00, 0, 1, 1, 0, 40'h300 + 40'(16 * i), 9 + i, 1, 1);
      add(1, 6'h00, 0, 0, 0, 0, 0, 13, 1, 1);
      add(0, 6'h03, 40'h400, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 6'h01, 40'h500 + 40'(16 * i), 0, 1, 0, 40'h400, 0, 0, 0);
      add(0, 6'h00, 0, 1, 1, 0, 40'h400, 0, 0, 0);
      add(0, 6'h01, 40'h530, 1, 1, 1, 40'h404, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 6'h00, 0, 1, 1, 0, 40'h500 + 40'(16 * i), 2 + i, 0, 0);
      add(0, 6'h3F, 40'h600, 1, 0, 0, 0, 6, 0, 0);
      add(0, 6'h00, 0, 1, 1, 0, 40'h600, 6, 0, 0);
      add(0, 6'h00, 0, 1, 1, 1, 40'h604, 7, 0, 0);
      add(1, 6'h00, 0, 1, 1, 2, 40'h608, 8, 0, 0);
      add(0, 6'h01, 40'h700, 1, 0, 0, 0, 0, 0, 0);
      add(0, 6'h00, 0, 1, 1, 0, 40'h700, 0, 0, 0);
      add(0, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0);

      drive(1, 6'h3F, 0, 0, 1);
      @(negedge clock);
      drive(1, 6'h3F, 0, 1, 1);
      @(negedge clock);
      check_model();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_inst", 64'(out_inst), 64'd0);
      chk("rst_ldst", 64'(out_ldst), 64'd0);
      chk("rst_rtype", 64'(out_dst_rtype), 64'd0);
      chk("rst_wdata", out_wdata, 64'd0);
      chk("rst_lane", 64'(out_lane), 64'd0);
      chk("rst_hartid", 64'(out_hartid), 64'd0);

      for (int k = 0; k < rows.size(); k++) begin
         if (k > 0) @(negedge clock);
         check_model();
         chk($sformatf("row%0d_valid", k), 64'(out_valid), 64'(rows[k].ev));
         chk($sformatf("row%0d_seq", k), 64'(out_seq), 64'(rows[k].eseq));
         chk($sformatf("row%0d_overflow", k), 64'(overflow), 64'(rows[k].eovf));
         chk($sformatf("row%0d_drops", k), 64'(drop_count), 64'(rows[k].edrop));
         if (rows[k].ev) begin
            chk($sformatf("row%0d_lane", k), 64'(out_lane), 64'(rows[k].elane));
            chk($sformatf("row%0d_pc", k), 64'(out_pc), 64'(rows[k].epc));
         end
         drive(rows[k].rst, rows[k].mask, rows[k].base, rows[k].rdy, 0);
      end

      for (int c = 0; c < 3000; c++) begin
         logic [5:0] rmask;
         bit         rdy;
         bit         rst;
         @(negedge clock);
         check_model();
         rmask = ($urandom_range(0, 9) < 4) ? 6'd0 : 6'($urandom);
         if ((c % 400) < 100) rdy = ($urandom_range(0, 9) < 2);
         else rdy = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 499) == 0);
         drive(rst, rmask, 0, rdy, 1);
      end
      @(negedge clock);
      check_model();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
